// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for lock with timeout and
// retry, qualifies lock stability, then releases the pixel-clock reset.
// Everything runs in the reference-clock domain; pll_locked is synchronized.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_lost_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // Terminal counts: each phase ends when cnt reaches its last cycle index.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             lock_sync_p0, lock_sync_p1;
    logic             locked_s;

    assign locked_s = lock_sync_p1;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_p0 <= 1'b0;
            lock_sync_p1 <= 1'b0;
        end else begin
            lock_sync_p0 <= pll_locked;
            lock_sync_p1 <= lock_sync_p0;
        end
    end

    // State, phase counter and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= 4'd0;
            lost_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state logic; restart overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        // A lock loss in RUN is always counted, even if restart wins the transition.
        if (state_q == S_RUN && !locked_s && lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
        end

        if (restart) begin
            state_d = S_RESET_PLL;
            retry_d = 4'd0;
        end else begin
            unique case (state_q)
                S_RESET_PLL: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (locked_s) begin
                        state_d = S_STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = S_RESET_PLL;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                end
                S_STABILIZE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_RESET_PLL;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_RESET_PLL;
                end
            endcase
        end

        // Every phase starts counting from zero; restart in RESET_PLL restarts the pulse.
        if (restart || state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Registered Moore outputs, decoded from the state being entered so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            pll_rst   <= (state_d == S_RESET_PLL);
            sys_rst_n <= (state_d == S_RUN);
            ready     <= (state_d == S_RUN);
            fault     <= (state_d == S_FAULT);
        end
    end

    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;
    assign state         = state_q;

endmodule
